uart_tx: RTL and testbench

Serial UART transmitter: accepts a parallel byte over a valid/ready handshake and shifts it out as an asynchronous 8N1 frame on a single line. It is the transmit-side counterpart of the UART receiver in the same design, sharing its clock domain and bit-period convention. Baud timing is derived from the system clock by an internal bit-period counter, so no external baud tick is needed.

---
 rtl/uart_tx_if.sv | 22 ++
 rtl/uart_tx.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between a producer and the UART transmitter.
//   tx_data  [7:0]  byte offered by the producer
//   tx_valid        tx_data is valid
//   tx_ready        transmitter can accept a byte this cycle
// Modports: master (producer side), slave (transmitter side).
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter. A byte accepted over the valid/ready
// handshake is shifted out LSB first as an 8N1 frame, or as 8E1 when the
// UART_TX_PARITY_EN macro is defined. Baud timing comes from an internal
// bit-period counter of CLKS_PER_BIT system clocks per bit.
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   bus        uart_tx_if.slave (tx_data, tx_valid in; tx_ready out)
//   tx_o       serial line, idle high
//   tx_busy_o  frame in progress
//   tx_done_o  one-cycle pulse in the last cycle of the stop bit
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line high, ready for a byte
// S_START  | start bit (line low)
// S_DATA   | 8 data bits, LSB first
// S_PARITY | even parity bit (only with UART_TX_PARITY_EN)
// S_STOP   | stop bit (line high)
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave bus,
    output logic     tx_o,
    output logic     tx_busy_o,
    output logic     tx_done_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic bit_end;
    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d      = 1'b1;
                busy_d    = 1'b0;
                ready_d   = 1'b1;
                cnt_d     = '0;
                bit_idx_d = '0;
                // Handshake uses the registered ready so acceptance matches
                // what the producer saw on tx_ready this cycle.
                if (ready_q && bus.tx_valid) begin
                    state_d  = S_START;
                    shift_d  = bus.tx_data;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.tx_data;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Raised one count early so the registered pulse lands
                    // in the final cycle of the stop bit.
                    if (cnt_q == CNT_PRE) begin
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign bus.tx_ready = ready_q;
    assign tx_o         = tx_q;
    assign tx_busy_o    = busy_q;
    assign tx_done_o    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx. The reference
// model derives each expected line level from the frame layout
// (start, 8 data bits LSB first, optional even parity, stop) and the
// cycle offset from the handshake. Honours UART_TX_PARITY_EN.
module tb_uart_tx;
    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * N;
    localparam int HS_LIMIT  = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx, tx_busy, tx_done;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    uart_tx_if bus ();

    uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .tx_o      (tx),
        .tx_busy_o (tx_busy),
        .tx_done_o (tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Called at a negedge. Offers byte d, waits for the handshake and checks
    // every cycle of the frame plus the ready cycle that follows. If
    // abort_at >= 0, reset is asserted at that frame cycle instead.
    task automatic send(input logic [7:0] d, input bit keep_valid, input int abort_at,
                        output int hs_c);
        bit got_hs = 0;
        hs_c = -1;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        for (int k = 0; k < HS_LIMIT; k++) begin
            if (bus.tx_ready === 1'b1) begin
                got_hs = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got_hs) begin
            check("hs_timeout", 32'(1), 32'(0));
            bus.tx_valid = 1'b0;
            return;
        end
        hs_c = cyc;
        @(posedge clk);
        #1;
        if (!keep_valid) bus.tx_valid = 1'b0;
        bus.tx_data = 8'($urandom);
        for (int j = 0; j < FRAME_CYC; j++) begin
            @(negedge clk);
            if (j == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                for (int r = 0; r < 3; r++) begin
                    check("abort_tx",    32'(tx),            32'(1));
                    check("abort_done",  32'(tx_done),       32'(0));
                    check("abort_busy",  32'(tx_busy),       32'(0));
                    check("abort_ready", 32'(bus.tx_ready),  32'(0));
                    @(negedge clk);
                end
                rst_n = 1'b1;
                @(negedge clk);
                check("abort_rel_ready", 32'(bus.tx_ready), 32'(1));
                check("abort_rel_done",  32'(tx_done),      32'(0));
                return;
            end
            check("tx",    32'(tx),           32'(frame_bit(d, j / N)));
            check("busy",  32'(tx_busy),      32'(1));
            check("done",  32'(tx_done),      32'(j == FRAME_CYC - 1));
            check("ready", 32'(bus.tx_ready), 32'(0));
        end
        @(negedge clk);
        check("post_ready", 32'(bus.tx_ready), 32'(1));
        check("post_busy",  32'(tx_busy),      32'(0));
        check("post_tx",    32'(tx),           32'(1));
        check("post_done",  32'(tx_done),      32'(0));
    endtask

    initial begin
        int  h1, h2, hp;
        bit  keep, prev_keep;
        logic [7:0] d;

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        rst_n        = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_tx",    32'(tx),           32'(1));
            check("rst_ready", 32'(bus.tx_ready), 32'(0));
            check("rst_busy",  32'(tx_busy),      32'(0));
            check("rst_done",  32'(tx_done),      32'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(bus.tx_ready), 32'(1));
        check("rel_tx",    32'(tx),           32'(1));

        send(8'hA5, 1'b0, -1, h1);
        send(8'h07, 1'b0, -1, h1);
        send(8'h03, 1'b0, -1, h1);

        send(8'h00, 1'b1, -1, h1);
        send(8'hFF, 1'b0, -1, h2);
        check("b2b_gap", 32'(h2 - h1), 32'(FRAME_CYC + 1));

        // Reset during data bit 3 (frame bit index 4) of 0x5A.
        send(8'h5A, 1'b0, 4 * N + 1, h1);
        send(8'h3C, 1'b0, -1, h1);

        prev_keep = 0;
        hp = 0;
        for (int i = 0; i < 12; i++) begin
            d    = 8'($urandom);
            keep = (i < 11) ? bit'($urandom_range(0, 1)) : 1'b0;
            send(d, keep, -1, h1);
            if (prev_keep) check("rand_gap", 32'(h1 - hp), 32'(FRAME_CYC + 1));
            prev_keep = keep;
            hp = h1;
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
